// File: rtl/sd_cmd_tx_if.sv
// Command-request and CMD-line signals between the SD host controller and its command transmitter.
// The master side issues send requests; the slave side serialises the frame and reports its progress.
interface sd_cmd_tx_if;
   logic        send_en;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        sd_cmd_out;
   logic        sd_cmd_oe;
   logic        busy;
   logic        sd_send_started;
   logic        sd_send_finished;

   modport master (
      output send_en,
      output cmd_index,
      output cmd_arg,
      input  sd_cmd_out,
      input  sd_cmd_oe,
      input  busy,
      input  sd_send_started,
      input  sd_send_finished
   );

   modport slave (
      input  send_en,
      input  cmd_index,
      input  cmd_arg,
      output sd_cmd_out,
      output sd_cmd_oe,
      output busy,
      output sd_send_started,
      output sd_send_finished
   );
endinterface

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: start bit on the line one cycle after acceptance, 48 bits, then NCC_CYCLES idle.
// Requests are level-sampled only in IDLE; send_en is ignored (no queueing) while busy.
module sd_cmd_tx #(
   parameter int NCC_CYCLES = 8
) (
   input  logic        sd_clk,
   input  logic        reset,
   sd_cmd_tx_if.slave  bus
);

   localparam int NCC_W = (NCC_CYCLES > 0) ? $clog2(NCC_CYCLES + 1) : 1;
   localparam logic [NCC_W-1:0] NCC_LAST = (NCC_CYCLES > 0) ? NCC_W'(NCC_CYCLES - 1) : NCC_W'(0);
   localparam logic [5:0] LAST_SEND_BIT = 6'd39;
   localparam logic [5:0] LAST_CRC_BIT  = 6'd46;
   localparam logic [6:0] CRC7_POLY     = 7'h09;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_CRC,
      ST_END,
      ST_NCC
   } state_t;

   typedef struct packed {
      logic        start_bit;
      logic        tx_bit;
      logic [5:0]  index;
      logic [31:0] arg;
   } cmd_hdr_t;

   state_t           state_q, state_d;
   logic [39:0]      shreg_q, shreg_d;
   logic [6:0]       crc_q, crc_d;
   logic [5:0]       bitcnt_q, bitcnt_d;
   logic [NCC_W-1:0] ncc_q, ncc_d;

   logic out_q, out_d;
   logic oe_q, oe_d;
   logic busy_q, busy_d;
   logic started_q, started_d;
   logic finished_q, finished_d;

   cmd_hdr_t   hdr;
   logic       crc_fb;
   logic [6:0] crc_step;

   // State register plus the datapath and output flops that follow it.
   always_ff @(posedge sd_clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         crc_q      <= '0;
         bitcnt_q   <= '0;
         ncc_q      <= '0;
         out_q      <= 1'b1;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         started_q  <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         crc_q      <= crc_d;
         bitcnt_q   <= bitcnt_d;
         ncc_q      <= ncc_d;
         out_q      <= out_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         started_q  <= started_d;
         finished_q <= finished_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.send_en) state_d = ST_SEND;
         ST_SEND: if (bitcnt_q == LAST_SEND_BIT) state_d = ST_CRC;
         ST_CRC:  if (bitcnt_q == LAST_CRC_BIT) state_d = ST_END;
         ST_END:  state_d = (NCC_CYCLES == 0) ? ST_IDLE : ST_NCC;
         ST_NCC:  if (ncc_q == NCC_LAST) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // CRC7 accumulates over the 40 header bits as they leave, then is shifted out MSB first.
   always_comb begin
      hdr      = '{start_bit: 1'b0, tx_bit: 1'b1, index: bus.cmd_index, arg: bus.cmd_arg};
      crc_fb   = crc_q[6] ^ shreg_q[39];
      crc_step = {crc_q[5:0], 1'b0} ^ (crc_fb ? CRC7_POLY : 7'h00);
      shreg_d  = shreg_q;
      crc_d    = crc_q;
      bitcnt_d = bitcnt_q;
      ncc_d    = ncc_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.send_en) begin
               shreg_d  = hdr;
               crc_d    = '0;
               bitcnt_d = '0;
               ncc_d    = '0;
            end
         end
         ST_SEND: begin
            shreg_d  = {shreg_q[38:0], 1'b0};
            crc_d    = crc_step;
            bitcnt_d = bitcnt_q + 6'd1;
         end
         ST_CRC: begin
            crc_d    = {crc_q[5:0], 1'b0};
            bitcnt_d = bitcnt_q + 6'd1;
         end
         ST_END: begin
            bitcnt_d = bitcnt_q + 6'd1;
            ncc_d    = '0;
         end
         ST_NCC: begin
            if (ncc_q != NCC_LAST) ncc_d = ncc_q + NCC_W'(1);
         end
         default: begin
            shreg_d  = '0;
            crc_d    = '0;
            bitcnt_d = '0;
            ncc_d    = '0;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so every pad-facing signal leaves a flop.
   always_comb begin
      out_d      = 1'b1;
      oe_d       = 1'b0;
      started_d  = 1'b0;
      finished_d = 1'b0;
      busy_d     = (state_d != ST_IDLE);
      case (state_d)
         ST_SEND: begin
            oe_d      = 1'b1;
            out_d     = shreg_d[39];
            started_d = (state_q == ST_IDLE);
         end
         ST_CRC: begin
            oe_d  = 1'b1;
            out_d = crc_d[6];
         end
         ST_END: begin
            oe_d  = 1'b1;
            out_d = 1'b1;
         end
         ST_IDLE: finished_d = (state_q != ST_IDLE);
         default: begin
            oe_d  = 1'b0;
            out_d = 1'b1;
         end
      endcase
   end

   assign bus.sd_cmd_out       = out_q;
   assign bus.sd_cmd_oe        = oe_q;
   assign bus.busy             = busy_q;
   assign bus.sd_send_started  = started_q;
   assign bus.sd_send_finished = finished_q;

   a_start_bit_low: assert property (@(posedge sd_clk) disable iff (reset)
      started_q |-> (oe_q && !out_q));
   a_drive_only_busy: assert property (@(posedge sd_clk) disable iff (reset)
      oe_q |-> busy_q);
   a_finish_released: assert property (@(posedge sd_clk) disable iff (reset)
      finished_q |-> (!busy_q && !oe_q && out_q));

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: two instances (NCC 8 and NCC 0) share stimulus and are checked every cycle
// against a frame/timeline model built from polynomial division and cycle-since-acceptance counting.
module tb_sd_cmd_tx;

   localparam int NCC0 = 8;
   localparam int NCC1 = 0;

   logic        sd_clk    = 1'b0;
   logic        reset     = 1'b1;
   logic        send_en   = 1'b0;
   logic [5:0]  cmd_index = '0;
   logic [31:0] cmd_arg   = '0;

   int errs   = 0;
   int checks = 0;

   sd_cmd_tx_if bus0 ();
   sd_cmd_tx_if bus1 ();

   assign bus0.send_en   = send_en;
   assign bus0.cmd_index = cmd_index;
   assign bus0.cmd_arg   = cmd_arg;
   assign bus1.send_en   = send_en;
   assign bus1.cmd_index = cmd_index;
   assign bus1.cmd_arg   = cmd_arg;

   sd_cmd_tx #(.NCC_CYCLES(NCC0)) dut0 (.sd_clk(sd_clk), .reset(reset), .bus(bus0));
   sd_cmd_tx #(.NCC_CYCLES(NCC1)) dut1 (.sd_clk(sd_clk), .reset(reset), .bus(bus1));

   always #5 sd_clk = ~sd_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame = header followed by the remainder of header*x^7 divided by x^7+x^3+1, then the end bit.
   function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] d;
      logic [46:0] r;
      d = {2'b01, idx, arg};
      r = {d, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return {d, r[6:0], 1'b1};
   endfunction

   // {out, oe, busy, started, finished} in cycle t after acceptance (t = 0 means no frame).
   function automatic logic [4:0] expect_out(input int t, input int n, input logic [47:0] f);
      logic o;
      o = 1'b1;
      if (t >= 1 && t <= 48) o = f[48 - t];
      return {o, (t >= 1 && t <= 48), (t >= 1 && t <= 48 + n), (t == 1), (t == 49 + n)};
   endfunction

   int          mt0 = 0, mt1 = 0;
   logic [47:0] mf0 = '0, mf1 = '0;

   task automatic model_step(inout int t, inout logic [47:0] f, input int n);
      if (reset) t = 0;
      else if (t == 0 || t >= 49 + n) begin
         if (send_en) begin
            t = 1;
            f = make_frame(cmd_index, cmd_arg);
         end else t = 0;
      end else t++;
   endtask

   always @(posedge sd_clk) begin
      model_step(mt0, mf0, NCC0);
      model_step(mt1, mf1, NCC1);
   end

   always @(negedge sd_clk) begin
      logic [4:0] e0, e1;
      e0 = reset ? 5'b10000 : expect_out(mt0, NCC0, mf0);
      e1 = reset ? 5'b10000 : expect_out(mt1, NCC1, mf1);
      chk("line_ncc8", {bus0.sd_cmd_out, bus0.sd_cmd_oe, bus0.busy,
                        bus0.sd_send_started, bus0.sd_send_finished}, e0);
      chk("line_ncc0", {bus1.sd_cmd_out, bus1.sd_cmd_oe, bus1.busy,
                        bus1.sd_send_started, bus1.sd_send_finished}, e1);
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bus0.busy || bus1.busy) && n < 300) begin
         @(posedge sd_clk); #1;
         n++;
      end
      chk("idle_timeout", {bus0.busy, bus1.busy}, 2'b00);
   endtask

   // mode 0 plain, 1 poke inputs mid-frame, 2 reset mid-frame, 3 hold send_en for a repeat.
   task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input int mode,
                            output logic [47:0] cap, output int fin0, output int fin1,
                            output int oe1_fall, output int start1, output int start2,
                            output int nstart);
      cmd_index = idx;
      cmd_arg   = arg;
      send_en   = 1'b1;
      @(posedge sd_clk); #1;
      if (mode != 3) send_en = 1'b0;
      cap = '0; fin0 = 0; fin1 = 0; oe1_fall = 0; start1 = 0; start2 = 0; nstart = 0;
      for (int k = 1; k <= 70; k++) begin
         if (mode == 1 && k == 20) begin
            cmd_index = 6'h3F;
            cmd_arg   = 32'hFFFF_FFFF;
            send_en   = 1'b1;
         end
         if (mode == 1 && k == 21) send_en = 1'b0;
         if (mode == 2 && k == 20) begin
            reset = 1'b1;
            #1;
            chk("abort_oe", bus0.sd_cmd_oe, 1'b0);
            chk("abort_out", bus0.sd_cmd_out, 1'b1);
            chk("abort_busy", bus0.busy, 1'b0);
         end
         if (mode == 2 && k == 22) reset = 1'b0;
         if (mode == 3 && k == 60) send_en = 1'b0;
         @(negedge sd_clk);
         if (k <= 48) cap[48 - k] = bus0.sd_cmd_out;
         if (bus0.sd_send_finished && fin0 == 0) fin0 = k;
         if (bus1.sd_send_finished && fin1 == 0) fin1 = k;
         if (!bus1.sd_cmd_oe && oe1_fall == 0) oe1_fall = k;
         if (bus0.sd_send_started) begin
            nstart++;
            if (start1 == 0) start1 = k;
            else if (start2 == 0) start2 = k;
         end
         @(posedge sd_clk); #1;
      end
   endtask

   initial begin
      logic [47:0] cap;
      int f0, f1, of, s1, s2, ns;

      repeat (3) @(posedge sd_clk);
      #1;
      chk("rst_out", bus0.sd_cmd_out, 1'b1);
      chk("rst_oe", bus0.sd_cmd_oe, 1'b0);
      chk("rst_busy", bus0.busy, 1'b0);
      chk("rst_started", bus0.sd_send_started, 1'b0);
      chk("rst_finished", bus0.sd_send_finished, 1'b0);
      reset = 1'b0;
      @(posedge sd_clk); #1;

      chk("model_cmd0", make_frame(6'd0, 32'h0), 48'h40_00000000_95);
      chk("model_cmd8", make_frame(6'd8, 32'h1AA), 48'h48_000001AA_87);
      chk("model_cmd17", make_frame(6'd17, 32'h0), 48'h51_00000000_55);

      run_frame(6'd0, 32'h0, 0, cap, f0, f1, of, s1, s2, ns);
      chk("cmd0_frame", cap, 48'h40_00000000_95);
      chk("cmd0_started_cycle", s1, 1);
      chk("cmd0_finished_cycle", f0, 57);
      chk("ncc0_finished_cycle", f1, 49);
      chk("ncc0_oe_fall_cycle", of, 49);
      wait_idle();

      run_frame(6'd8, 32'h0000_01AA, 0, cap, f0, f1, of, s1, s2, ns);
      chk("cmd8_frame", cap, 48'h48_000001AA_87);
      chk("cmd8_crc7", cap[7:1], 7'h43);
      wait_idle();

      run_frame(6'd17, 32'h0, 3, cap, f0, f1, of, s1, s2, ns);
      chk("cmd17_frame", cap, 48'h51_00000000_55);
      chk("held_restart_cycle", s2, 58);
      wait_idle();

      run_frame(6'd8, 32'h0000_01AA, 1, cap, f0, f1, of, s1, s2, ns);
      chk("poke_frame", cap, 48'h48_000001AA_87);
      chk("poke_finished_cycle", f0, 57);
      chk("poke_start_count", ns, 1);
      wait_idle();

      run_frame(6'd17, 32'h0, 2, cap, f0, f1, of, s1, s2, ns);
      chk("abort_no_finish_ncc8", f0, 0);
      chk("abort_no_finish_ncc0", f1, 0);
      wait_idle();

      run_frame(6'd0, 32'h0, 0, cap, f0, f1, of, s1, s2, ns);
      chk("post_abort_frame", cap, 48'h40_00000000_95);
      chk("post_abort_finished", f0, 57);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
